// File: rtl/mux_reg_scan.sv
// Registered channel selector with manual select and auto-scan modes.
// One-slot valid/ready output register; scan captures stall under backpressure.
module mux_reg_scan #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned NCH      = 3,
    parameter int unsigned DWELL    = 4,
    parameter int unsigned OOR_ZERO = 0,
    localparam int unsigned SELW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 z_ready,
    output logic [WIDTH-1:0]     z,
    output logic                 z_valid,
    output logic [SELW-1:0]      cur_ch
);

    localparam int unsigned CNTW = $clog2(DWELL + 1);
    localparam logic [CNTW-1:0] DwellLast = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] LastCh    = SELW'(NCH - 1);

    typedef enum logic [0:0] {StMan, StScan} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  z_q, z_d;
    logic              z_valid_q, z_valid_d;
    logic [SELW-1:0]   cur_ch_q, cur_ch_d;
    logic [CNTW-1:0]   dwell_cnt_q, dwell_cnt_d;

    logic              slot_free;
    logic              accept;
    logic              sel_in_range;
    logic [WIDTH-1:0]  sel_data;
    logic [WIDTH-1:0]  scan_data;

    assign slot_free    = !z_valid_q || z_ready;
    assign accept       = z_valid_q && z_ready;
    // Extra bit so the check still works when NCH is a power of two.
    assign sel_in_range = ({1'b0, sel} < (SELW + 1)'(NCH));

    always_comb begin
        sel_data  = '0;
        scan_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == SELW'(k)) sel_data = din[k*WIDTH +: WIDTH];
            if (cur_ch_q == SELW'(k)) scan_data = din[k*WIDTH +: WIDTH];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= StMan;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StMan:   if (mode)  state_d = StScan;
            StScan:  if (!mode) state_d = StMan;
            default: state_d = StMan;
        endcase
    end

    // Datapath next-state; transition cycles never load
    always_comb begin
        z_d         = z_q;
        z_valid_d   = accept ? 1'b0 : z_valid_q;
        cur_ch_d    = cur_ch_q;
        dwell_cnt_d = dwell_cnt_q;
        unique case (state_q)
            StMan: begin
                if (mode) begin
                    cur_ch_d    = '0;
                    dwell_cnt_d = '0;
                end else if (enable && slot_free) begin
                    if (sel_in_range) begin
                        z_d       = sel_data;
                        z_valid_d = 1'b1;
                        cur_ch_d  = sel;
                    end else if (OOR_ZERO != 0) begin
                        z_d       = '0;
                        z_valid_d = 1'b0;
                    end
                end
            end
            StScan: begin
                if (mode && enable) begin
                    if (dwell_cnt_q < DwellLast) begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end else if (slot_free) begin
                        z_d         = scan_data;
                        z_valid_d   = 1'b1;
                        dwell_cnt_d = '0;
                        cur_ch_d    = (cur_ch_q == LastCh) ? '0 : cur_ch_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            z_q         <= '0;
            z_valid_q   <= 1'b0;
            cur_ch_q    <= '0;
            dwell_cnt_q <= '0;
        end else begin
            z_q         <= z_d;
            z_valid_q   <= z_valid_d;
            cur_ch_q    <= cur_ch_d;
            dwell_cnt_q <= dwell_cnt_d;
        end
    end

    // Outputs come straight from registers
    always_comb begin
        z       = z_q;
        z_valid = z_valid_q;
        cur_ch  = cur_ch_q;
    end

endmodule
